// File: rtl/pico_board_seq_if.sv
// PicoBlaze port-mapped sequencer that checks or commits a list of board-RAM cells,
// aggregating validity into status registers, and owns the interrupt latch.
module pico_board_seq_if #(
    parameter logic [7:0]        PORT_BASE   = 8'h20,
    parameter int                MAX_CELLS   = 5,
    parameter int                ADDR_W      = 8,
    parameter int                DATA_W      = 2,
    parameter int                RAM_LAT     = 1,
    parameter logic [ADDR_W-1:0] OOB_ADDR    = {ADDR_W{1'b1}},
    parameter bit                IRQ_ON_DONE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        port_id,
    input  logic [7:0]        out_port,
    input  logic              write_strobe,
    output logic [7:0]        in_port,
    input  logic              interrupt_ack,
    input  logic              int_request,
    output logic              interrupt,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              seq_busy
);
    localparam int CNT_W = $clog2(MAX_CELLS + 1);
    localparam logic [7:0] P_LIST = PORT_BASE;
    localparam logic [7:0] P_CMD  = PORT_BASE + 8'd1;
    localparam logic [7:0] P_WDAT = PORT_BASE + 8'd2;
    localparam logic [7:0] P_STAT = PORT_BASE + 8'd3;
    localparam logic [7:0] P_FIDX = PORT_BASE + 8'd4;

    localparam logic [2:0] S_IDLE = 3'd0, S_RD_ISSUE = 3'd1, S_RD_WAIT = 3'd2,
                           S_EVAL = 3'd3, S_WR = 3'd4, S_FIN = 3'd5;

    logic [MAX_CELLS-1:0][ADDR_W-1:0] list_q, list_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, idx_q, idx_d;
    logic [2:0]        state_q, state_d;
    logic [1:0]        lat_q, lat_d;
    logic [DATA_W-1:0] rdata_q, rdata_d, wdata_q, wdata_d, ram_wdata_q, ram_wdata_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        fail_idx_q, fail_idx_d, in_port_q, in_port_d;
    logic overflow_q, overflow_d, cmd_err_q, cmd_err_d, done_q, done_d, valid_q, valid_d;
    logic ram_we_q, ram_we_d, busy_q, busy_d, irq_q, irq_d;
    logic wr_list, wr_cmd, wr_wdat, cmd_clear, cmd_chk, cmd_com, cmd_bad, busy, seq_irq;

    function automatic logic [ADDR_W-1:0] cell_at(input logic [CNT_W-1:0] i);
        logic [ADDR_W-1:0] r;
        r = '0;
        for (int k = 0; k < MAX_CELLS; k++)
            if (CNT_W'(k) == i) r = list_q[k];
        return r;
    endfunction

    assign wr_list   = write_strobe && (port_id == P_LIST);
    assign wr_cmd    = write_strobe && (port_id == P_CMD);
    assign wr_wdat   = write_strobe && (port_id == P_WDAT);
    assign cmd_clear = wr_cmd && out_port[7];
    assign cmd_chk   = wr_cmd && !out_port[7] && out_port[0] && !out_port[1];
    assign cmd_com   = wr_cmd && !out_port[7] && out_port[1] && !out_port[0];
    assign cmd_bad   = wr_cmd && !out_port[7] && (out_port[0] == out_port[1]);
    assign busy      = (state_q != S_IDLE);

    always_comb begin
        list_d = list_q;  cnt_d = cnt_q;  idx_d = idx_q;  state_d = state_q;
        lat_d = lat_q;  rdata_d = rdata_q;  wdata_d = wdata_q;  fail_idx_d = fail_idx_q;
        overflow_d = overflow_q;  cmd_err_d = cmd_err_q;  done_d = done_q;  valid_d = valid_q;
        seq_irq = 1'b0;

        if (wr_list) begin
            if (busy) cmd_err_d = 1'b1;
            else if (cnt_q == CNT_W'(MAX_CELLS)) overflow_d = 1'b1;
            else begin
                for (int k = 0; k < MAX_CELLS; k++)
                    if (CNT_W'(k) == cnt_q) list_d[k] = out_port[ADDR_W-1:0];
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (wr_wdat) begin
            if (busy) cmd_err_d = 1'b1;
            else wdata_d = out_port[DATA_W-1:0];
        end
        if (wr_cmd && !out_port[7] && (busy || cmd_bad)) cmd_err_d = 1'b1;

        case (state_q)
            S_IDLE: if (cmd_chk || cmd_com) begin
                valid_d = 1'b0;  fail_idx_d = 8'hFF;  idx_d = '0;  done_d = 1'b0;
                if (cnt_q == '0) begin
                    done_d = 1'b1;  state_d = S_FIN;
                end else if (cmd_chk)
                    state_d = (cell_at('0) == OOB_ADDR) ? S_EVAL : S_RD_ISSUE;
                else
                    state_d = S_WR;
            end
            S_RD_ISSUE: begin
                lat_d = '0;  state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                // Capture exactly RAM_LAT cycles after the address was issued
                if (lat_q == 2'(RAM_LAT - 1)) begin
                    rdata_d = ram_rdata;  state_d = S_EVAL;
                end else lat_d = lat_q + 1'b1;
            end
            S_EVAL: begin
                if (cell_at(idx_q) == OOB_ADDR || rdata_q != '0) begin
                    fail_idx_d = 8'(idx_q);  valid_d = 1'b0;  done_d = 1'b1;  state_d = S_FIN;
                end else if (idx_q == cnt_q - 1'b1) begin
                    valid_d = 1'b1;  done_d = 1'b1;  state_d = S_FIN;
                end else begin
                    idx_d = idx_q + 1'b1;
                    state_d = (cell_at(idx_q + 1'b1) == OOB_ADDR) ? S_EVAL : S_RD_ISSUE;
                end
            end
            S_WR: begin
                if (idx_q == cnt_q - 1'b1) begin
                    done_d = 1'b1;  state_d = S_FIN;
                end else idx_d = idx_q + 1'b1;
            end
            S_FIN: begin
                seq_irq = IRQ_ON_DONE;  state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (cmd_clear) begin
            cnt_d = '0;  idx_d = '0;  overflow_d = 1'b0;  cmd_err_d = 1'b0;
            done_d = 1'b0;  valid_d = 1'b0;  state_d = S_IDLE;  seq_irq = 1'b0;
        end
    end

    // RAM-side outputs are registered from the next state so they line up with it
    always_comb begin
        ram_we_d    = (state_d == S_WR) && (cell_at(idx_d) != OOB_ADDR);
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if (state_d == S_RD_ISSUE || ram_we_d) ram_addr_d = cell_at(idx_d);
        if (ram_we_d) ram_wdata_d = wdata_q;
        busy_d = (state_d != S_IDLE);
        irq_d  = interrupt_ack ? 1'b0 : ((int_request || seq_irq) ? 1'b1 : irq_q);
        case (port_id)
            P_LIST:  in_port_d = 8'(cnt_q);
            P_WDAT:  in_port_d = 8'(wdata_q);
            P_STAT:  in_port_d = {busy_q, done_q, valid_q, overflow_q, cmd_err_q, 3'b000};
            P_FIDX:  in_port_d = fail_idx_q;
            default: in_port_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            list_q <= '0;  cnt_q <= '0;  idx_q <= '0;  state_q <= S_IDLE;  lat_q <= '0;
            rdata_q <= '0;  wdata_q <= '0;  fail_idx_q <= 8'hFF;  in_port_q <= 8'h00;
            overflow_q <= 1'b0;  cmd_err_q <= 1'b0;  done_q <= 1'b0;  valid_q <= 1'b0;
            ram_addr_q <= '0;  ram_we_q <= 1'b0;  ram_wdata_q <= '0;  busy_q <= 1'b0;  irq_q <= 1'b0;
        end else begin
            list_q <= list_d;  cnt_q <= cnt_d;  idx_q <= idx_d;  state_q <= state_d;  lat_q <= lat_d;
            rdata_q <= rdata_d;  wdata_q <= wdata_d;  fail_idx_q <= fail_idx_d;  in_port_q <= in_port_d;
            overflow_q <= overflow_d;  cmd_err_q <= cmd_err_d;  done_q <= done_d;  valid_q <= valid_d;
            ram_addr_q <= ram_addr_d;  ram_we_q <= ram_we_d;  ram_wdata_q <= ram_wdata_d;
            busy_q <= busy_d;  irq_q <= irq_d;
        end
    end

    assign in_port   = in_port_q;
    assign interrupt = irq_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;
    assign seq_busy  = busy_q;
endmodule

// File: tb/tb_pico_board_seq_if.sv
// Directed plus randomized bench for pico_board_seq_if with a behavioural board RAM
// and a cell-list reference model.
module tb_pico_board_seq_if;
    localparam logic [7:0] PB = 8'h20;
    localparam int L = 1;

    logic clk = 1'b0, reset = 1'b1, write_strobe = 1'b0, interrupt_ack = 1'b0, int_request = 1'b0;
    logic [7:0] port_id = 8'h00, out_port = 8'h00, in_port;
    logic interrupt, ram_we, seq_busy;
    logic [7:0] ram_addr;
    logic [1:0] ram_wdata, ram_rdata, rd_pipe = 2'b00;

    logic [1:0] mem [256];
    logic [9:0] wlog [$];
    int errors = 0, checks = 0;

    pico_board_seq_if #(.PORT_BASE(PB), .MAX_CELLS(5), .ADDR_W(8), .DATA_W(2), .RAM_LAT(L),
                        .OOB_ADDR(8'hFF), .IRQ_ON_DONE(1'b1)) dut (
        .clk(clk), .reset(reset), .port_id(port_id), .out_port(out_port),
        .write_strobe(write_strobe), .in_port(in_port), .interrupt_ack(interrupt_ack),
        .int_request(int_request), .interrupt(interrupt), .ram_addr(ram_addr),
        .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .seq_busy(seq_busy));

    always #5 clk = ~clk;

    // Board RAM: one-cycle registered read, write log for commit checks
    always @(posedge clk) begin
        rd_pipe <= mem[ram_addr];
        if (ram_we) begin
            mem[ram_addr] = ram_wdata;
            wlog.push_back({ram_addr, ram_wdata});
        end
    end
    assign ram_rdata = rd_pipe;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] off, input logic [7:0] d);
        @(negedge clk);
        port_id = PB + off;  out_port = d;  write_strobe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0;
    endtask

    task automatic rd(input logic [7:0] off, output logic [7:0] v);
        @(negedge clk);
        port_id = PB + off;
        @(negedge clk);
        v = in_port;
    endtask

    task automatic wait_idle(output int cyc, output int we_cyc);
        cyc = 0;  we_cyc = 0;
        while (seq_busy === 1'b1 && cyc < 1000) begin
            if (ram_we === 1'b1) we_cyc++;
            @(negedge clk);
            cyc++;
        end
        chk("busy_bound", 32'(cyc < 1000), 1);
    endtask

    task automatic ack_irq();
        @(negedge clk);  interrupt_ack = 1'b1;
        @(negedge clk);  interrupt_ack = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] al [5];
        int cyc, wec, n, exp_cyc;
        logic [7:0] exp_fail;

        for (int i = 0; i < 256; i++) mem[i] = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_in_port", in_port, 8'h00);
        chk("rst_irq", interrupt, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_busy", seq_busy, 0);
        chk("rst_addr", ram_addr, 8'h00);
        reset = 1'b0;
        rd(0, v); chk("rst_cnt", v, 8'h00);
        rd(3, v); chk("rst_status", v, 8'h00);
        rd(4, v); chk("rst_fidx", v, 8'hFF);
        rd(2, v); chk("rst_wdata", v, 8'h00);

        // Five clear cells: full-length CHECK
        for (int a = 12; a <= 16; a++) wr(0, 8'(a));
        rd(0, v); chk("cnt5", v, 8'h05);
        wr(1, 8'h01);
        port_id = PB + 8'd3;
        wait_idle(cyc, wec);
        chk("chk5_cycles", cyc, 5 * (L + 2) + 1);
        chk("chk5_status_fin", in_port, 8'hE0);
        chk("chk5_irq", interrupt, 1);
        @(negedge clk);
        chk("chk5_status", in_port, 8'h60);
        rd(4, v); chk("chk5_fidx", v, 8'hFF);
        ack_irq();
        chk("ack_clears", interrupt, 0);

        // Second cell occupied: early stop
        wr(1, 8'h80);
        mem[13] = 2'd2;
        wr(0, 12); wr(0, 13); wr(0, 14);
        wr(1, 8'h01);
        wait_idle(cyc, wec);
        chk("fail_cycles", cyc, 2 * (L + 2) + 1);
        rd(4, v); chk("fail_idx", v, 8'h01);
        rd(3, v); chk("fail_status", v, 8'h40);
        ack_irq();

        // COMMIT skipping an OOB cell
        wr(1, 8'h80);
        wr(0, 40); wr(0, 8'hFF); wr(0, 42);
        wr(2, 8'h01);
        wlog.delete();
        wr(1, 8'h02);
        wait_idle(cyc, wec);
        chk("com_cycles", cyc, 4);
        chk("com_we_cycles", wec, 2);
        chk("com_wlog_n", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("com_w0", wlog[0], {8'd40, 2'd1});
            chk("com_w1", wlog[1], {8'd42, 2'd1});
        end
        chk("com_mem40", mem[40], 1);
        chk("com_mem255", mem[255], 0);
        rd(3, v); chk("com_done", v[6], 1);
        ack_irq();

        // Overflow, command while busy, CLEAR
        wr(1, 8'h80);
        for (int a = 50; a <= 55; a++) wr(0, 8'(a));
        rd(0, v); chk("ovf_cnt", v, 8'h05);
        rd(3, v); chk("ovf_status", v, 8'h10);
        wr(1, 8'h01);
        wr(1, 8'h01);
        wait_idle(cyc, wec);
        rd(3, v); chk("cmderr_status", v, 8'h78);
        wr(1, 8'h80);
        rd(3, v); chk("clear_status", v, 8'h00);
        rd(0, v); chk("clear_cnt", v, 8'h00);
        ack_irq();
        wr(1, 8'h03);
        rd(3, v); chk("badcmd_status", v, 8'h08);

        // Empty list
        wr(1, 8'h80);
        wr(1, 8'h01);
        wait_idle(cyc, wec);
        chk("empty_cycles", cyc, 1);
        rd(4, v); chk("empty_fidx", v, 8'hFF);
        rd(3, v); chk("empty_status", v, 8'h40);
        ack_irq();

        // Randomized CHECK against list-level model
        for (int it = 0; it < 8; it++) begin
            wr(1, 8'h80);
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                if ($urandom % 5 == 0) al[i] = 8'hFF;
                else begin
                    al[i] = 8'(64 + $urandom % 64);
                    mem[al[i]] = ($urandom % 4 == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
                end
            end
            exp_fail = 8'hFF;  exp_cyc = 1;
            for (int i = 0; i < n; i++)
                if (exp_fail == 8'hFF) begin
                    exp_cyc += (al[i] == 8'hFF) ? 1 : L + 2;
                    if (al[i] == 8'hFF || mem[al[i]] != 0) exp_fail = 8'(i);
                end
            for (int i = 0; i < n; i++) wr(0, al[i]);
            wr(1, 8'h01);
            wait_idle(cyc, wec);
            chk("rnd_cycles", cyc, exp_cyc);
            rd(4, v); chk("rnd_fidx", v, exp_fail);
            rd(3, v); chk("rnd_status", v, (exp_fail == 8'hFF) ? 8'h60 : 8'h40);
            ack_irq();
        end

        // Interrupt latch priority
        @(negedge clk); int_request = 1'b1; interrupt_ack = 1'b1;
        @(negedge clk); int_request = 1'b0; interrupt_ack = 1'b0;
        chk("irq_ack_wins", interrupt, 0);
        @(negedge clk); int_request = 1'b1;
        @(negedge clk); int_request = 1'b0;
        chk("irq_ext", interrupt, 1);
        @(negedge clk);
        chk("irq_hold", interrupt, 1);
        ack_irq();
        chk("irq_ext_ack", interrupt, 0);

        // Reset mid-COMMIT
        wr(1, 8'h80);
        wr(0, 60); wr(0, 61); wr(0, 62);
        wr(2, 8'h02);
        wr(1, 8'h02);
        chk("mid_we", ram_we, 1);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_we", ram_we, 0);
        chk("mid_rst_busy", seq_busy, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_irq", interrupt, 0);
        rd(0, v); chk("mid_rst_cnt", v, 8'h00);
        rd(2, v); chk("mid_rst_wdata", v, 8'h00);
        rd(3, v); chk("mid_rst_status", v, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pico_board_seq_if.md
# pico_board_seq_if

Parametrised PicoBlaze I/O peripheral that sequences multi-cell board-RAM accesses for ship placement. Firmware loads up to MAX_CELLS cell addresses, then issues one CHECK or COMMIT command. The block reads or writes every cell autonomously, aggregates validity and reports status, so firmware no longer checks cells one port at a time. It sits between the KCPSM6 port bus and the board block RAM, alongside the existing Nexys4 I/O interface, and owns the closed-loop interrupt latch.

## Interface
- PORT_BASE, 8'h20, base port address; the block decodes PORT_BASE+0..+4
- MAX_CELLS, 5, cell list depth (1..8)
- ADDR_W, 8, RAM address width (<=8)
- DATA_W, 2, RAM data width (<=8)
- RAM_LAT, 1, RAM read latency in cycles (1..3)
- OOB_ADDR, all-ones ADDR_W, out-of-bounds marker address
- IRQ_ON_DONE, 1, sequence completion also raises interrupt
---
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- port_id  in  8  KCPSM6 port address
- out_port  in  8  KCPSM6 write data
- write_strobe  in  1  qualifies writes
- in_port  out  8  registered read data to KCPSM6
- interrupt_ack  in  1  KCPSM6 acknowledge
- int_request  in  1  external interrupt request
- interrupt  out  1  interrupt to KCPSM6
- ram_addr  out  ADDR_W  board RAM address
- ram_we  out  1  board RAM write enable
- ram_wdata  out  DATA_W  board RAM write data
- ram_rdata  in  DATA_W  board RAM read data
- seq_busy  out  1  sequencer active

## Operation
- Port map, offsets from PORT_BASE:
  - +0 W: append out_port[ADDR_W-1:0] at list[cnt], then cnt++. R: {0, cnt}.
  - +1 W CMD: bit7 CLEAR (cnt=0, clears overflow/cmd_err/done/valid, other bits ignored); bit0 CHECK; bit1 COMMIT.
  - +2 W/R: WDATA, out_port[DATA_W-1:0].
  - +3 R STATUS: {busy, done, valid, overflow, cmd_err, 3'b0}.
  - +4 R FAIL_IDX: index of first failing cell; 8'hFF if none.
- Unmapped reads return 8'h00. in_port is registered every cycle from port_id, one-cycle latency.
- Append when cnt==MAX_CELLS: ignored, overflow set (sticky).
- Append, WDATA write or CMD while busy: ignored, cmd_err set (sticky). CLEAR is the exception: it also aborts while busy (see below).
- CMD with CHECK and COMMIT both set, or neither set without CLEAR: cmd_err set, no start.
- A cell is valid iff addr != OOB_ADDR and rdata == 0. An OOB cell is not read; it fails immediately in EVAL.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, EVAL, WR, FIN.
  - CHECK: IDLE -> RD_ISSUE (ram_addr=list[i], we=0) -> RD_WAIT (RAM_LAT cycles) -> EVAL. In EVAL, a failing cell sets fail_idx=i, valid=0 and goes to FIN. Otherwise i++; the next cell goes to RD_ISSUE, and after the last cell valid=1 and the FSM goes to FIN.
  - COMMIT: IDLE -> WR. One cell per cycle with ram_addr=list[i], ram_wdata=WDATA, ram_we=1, except OOB cells, which keep ram_we=0 but still consume a cycle. After the last cell -> FIN.
  - FIN: done=1, busy=0 -> IDLE. Pulses the internal seq_irq if IRQ_ON_DONE.
- CHECK or COMMIT on an empty list: straight to FIN with valid=0 and fail_idx=8'hFF.
- done and valid are cleared when a new command starts.
- CLEAR while busy: abort to IDLE next cycle, ram_we=0, no done.
- Interrupt latch: interrupt_ack clears. Otherwise int_request or seq_irq sets. Otherwise hold. ack wins on coincidence.
- Reset values: in_port 0, interrupt 0, ram_addr 0, ram_we 0, ram_wdata 0, seq_busy 0, cnt 0, all status bits 0, fail_idx 8'hFF, WDATA 0.
- Reset mid-sequence: next edge returns to IDLE with ram_we=0; the list is lost.

## Timing
- All outputs are registered.
- CMD write at edge t0: seq_busy=1 after t0.
- CHECK, all n cells valid: done=1 and seq_busy=0 after edge t0 + n*(RAM_LAT+2) + 1. It stops early on the first failure.
- COMMIT of n cells: ram_we is high during cycles t0+1 .. t0+n (minus OOB cells); done follows at t0+n+1.
- ram_rdata is sampled exactly RAM_LAT cycles after ram_addr is presented in RD_ISSUE.
- interrupt rises one cycle after int_request or FIN, and falls one cycle after interrupt_ack.
- Status read: out of FIN, visible on in_port one cycle after port_id selects +3.

## Test plan
- Reset, then read +0, +3, +4 -> 8'h00, 8'h00, 8'hFF; interrupt=0; ram_we=0.
- Append 5 addrs 12,13,14,15,16 with RAM all zero, RAM_LAT=1, then CHECK -> busy 16 cycles; STATUS=8'hE0 while busy, then 8'h60; FIN interrupt; ack clears it.
- Append 3 cells, RAM[13]=2, CHECK -> fail_idx=1; valid=0; only 2 cells read.
- Append 40,OOB,42, WDATA=1, COMMIT -> ram_we high 2 of 3 cycles, writing 1 at 40 and 42; never at 8'hFF.
- 6th append with MAX_CELLS=5 -> overflow=1 and cnt=5; CMD during busy -> cmd_err=1; CLEAR -> both cleared, cnt=0.
- Reset asserted mid-COMMIT -> ram_we=0 next cycle; seq_busy=0; no interrupt. Same-cycle int_request and interrupt_ack -> interrupt stays 0.
